sort_list_reader: RTL and testbench
===================================

// Module: sort_list_reader
// PURPOSE
//  Read side of the check-node insertion-sort chain. Consumes the sorted candidate
//  stream (LLR, Q, IndexA, IndexI) shifted out of the chain, smallest LLR first.
//  Keeps only the first (most reliable) occurrence of each GF symbol Q and stops
//  after NM unique entries. Emits the truncated list over a valid/ready stream to
//  the check-to-variable message buffer.
// PARAMETERS
//  LLR_Width     5   MSB index of LLR field (field is LLR_Width+1 bits, unsigned, smaller = better)
//  Q_Width       6   MSB index of symbol field (Q_Width+1 bits)
//  IndexA_Width  5   MSB index of IndexA field
//  IndexI_Width  5   MSB index of IndexI field
//  NM            8   max unique entries emitted per frame (1..2**(Q_Width+1))
// PORTS
//  clk          in   1               single clock, rising edge
//  reset_n      in   1               asynchronous, active-low reset
//  s_valid      in   1               sorted-chain beat valid
//  s_ready      out  1               beat accepted when s_valid&&s_ready
//  s_last       in   1               final beat of frame
//  s_llr        in   LLR_Width+1     candidate LLR
//  s_q          in   Q_Width+1       candidate symbol
//  s_indexa     in   IndexA_Width+1  candidate IndexA
//  s_indexi     in   IndexI_Width+1  candidate IndexI
//  m_valid      out  1               output entry valid
//  m_ready      in   1               downstream accepts entry
//  m_llr/m_q/m_indexa/m_indexi  out  same widths as s_*   registered output entry
//  done         out  1               1-cycle pulse: frame finished, all entries delivered
//  list_len     out  clog2(NM+1)     unique entries emitted this frame; valid while done=1
//  order_err    out  1               sticky: accepted LLR smaller than previous accepted LLR
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, seen-bitmap (2**(Q_Width+1) bits) cleared, count=0.
//  - Output register O drives m_*; loads on accepted unique beat; m_valid held, data
//    stable until m_ready. Latency s accept -> m_valid = 1 cycle.
//  - FSM IDLE->RUN on first s_valid (that beat accepted in RUN rules, same cycle).
//  - RUN: s_ready = !m_valid || m_ready. Accepted beat is unique iff seen[s_q]==0 and
//    count<NM: load O, set seen[s_q], count++, compare LLR with last accepted.
//    Non-unique beats dropped silently (still consumed).
//    count reaches NM without s_last -> DRAIN.
//  - DRAIN: s_ready=1, all beats dropped until s_last accepted.
//  - Any accepted s_last (unique, duplicate, or in DRAIN) -> DONE.
//  - DONE: s_ready=0; wait until O empty (m_valid==0, or handshake this cycle); then
//    done=1 for one cycle with list_len=count; next cycle IDLE with seen, count,
//    order_err cleared.
//  - order_err: unsigned compare vs previous accepted unique LLR only; sets sticky,
//    cleared on the DONE->IDLE transition.
//  - Simultaneous: last unique beat making count==NM with s_last -> DONE directly.
//    m_ready handshake and new load in same cycle -> O takes new beat, no bubble.
//  - Reset mid-frame: async clear of everything; partial frame lost, next frame clean.
// STRUCTURE
//  - Shared package: field widths, NM default, FSM state encoding (IDLE/RUN/DRAIN/DONE),
//    list_len width function.
//  - One sub-module: sym_seen_map (bitmap, test/set by q, one-cycle clear).
// TESTING
//  1 NM=8, q=3,5,3,7 llr=1,2,4,6, last on 4th, m_ready=1 -> out (3,1),(5,2),(7,6); done, list_len=3
//  2 10 distinct q, llr 0..9, NM=8 -> 8 outputs; beats 9,10 consumed with s_ready=1; done, len=8
//  3 m_ready=0 for 5 cycles, s_valid held -> m_* stable, s_ready=0, no beat lost or repeated
//  4 llr 4 then 2 (distinct q) -> order_err=1 after 2nd accept, stays until DONE->IDLE
//  5 reset_n low after 3 outputs -> m_valid=0 at once; next frame q=3 again is emitted
//  6 s_last on duplicate while O full and m_ready=0 -> done waits; pulses cycle after handshake

Source files
------------

// File: rtl/sort_list_reader_pkg.sv
// Shared widths, FSM encoding and sizing helper for the sorted-list read side.
package sort_list_reader_pkg;

    localparam int LLR_WIDTH_DEF    = 5;
    localparam int Q_WIDTH_DEF      = 6;
    localparam int INDEXA_WIDTH_DEF = 5;
    localparam int INDEXI_WIDTH_DEF = 5;
    localparam int NM_DEF           = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to hold an entry count of 0..nm.
    function automatic int len_width(input int nm);
        return (nm < 1) ? 1 : $clog2(nm + 1);
    endfunction

endpackage

// File: rtl/sort_list_reader_seen.sv
// One bit per GF symbol: combinational test, registered set, single-cycle clear.
module sym_seen_map
    import sort_list_reader_pkg::*;
#(
    parameter int Q_Width = Q_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           set_en,
    input  logic [Q_Width:0] q,
    output logic           hit
);

    localparam int DEPTH = 2 ** (Q_Width + 1);

    logic [DEPTH-1:0] map;

    assign hit = map[q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map <= '0;
        end else if (clear) begin
            map <= '0;
        end else if (set_en) begin
            map[q] <= 1'b1;
        end
    end

endmodule

// File: rtl/sort_list_reader.sv
// Keeps the first occurrence of each symbol from the sorted chain, truncates to NM
// entries, and streams them out through a single output register.
module sort_list_reader
    import sort_list_reader_pkg::*;
#(
    parameter int LLR_Width    = LLR_WIDTH_DEF,
    parameter int Q_Width      = Q_WIDTH_DEF,
    parameter int IndexA_Width = INDEXA_WIDTH_DEF,
    parameter int IndexI_Width = INDEXI_WIDTH_DEF,
    parameter int NM           = NM_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      s_last,
    input  logic [LLR_Width:0]        s_llr,
    input  logic [Q_Width:0]          s_q,
    input  logic [IndexA_Width:0]     s_indexa,
    input  logic [IndexI_Width:0]     s_indexi,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LLR_Width:0]        m_llr,
    output logic [Q_Width:0]          m_q,
    output logic [IndexA_Width:0]     m_indexa,
    output logic [IndexI_Width:0]     m_indexi,
    output logic                      done,
    output logic [len_width(NM)-1:0]  list_len,
    output logic                      order_err,
    output state_t                    state_dbg
);

    localparam int            CW   = len_width(NM);
    localparam logic [CW-1:0] NM_C = CW'(NM);

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic [LLR_Width:0] prev_llr;
    logic               have_prev;
    logic               seen_hit;
    logic               o_free;
    logic               accept;
    logic               new_sym;
    logic               finish;

    // Both streams: a beat transfers on a rising edge where valid && ready; the
    // producer holds valid and data steady until that edge.
    assign o_free  = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign new_sym = accept && (state == ST_IDLE || state == ST_RUN)
                     && !seen_hit && (count < NM_C);
    assign state_dbg = state;

    sym_seen_map #(.Q_Width(Q_Width)) u_seen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (finish),
        .set_en  (new_sym),
        .q       (s_q),
        .hit     (seen_hit)
    );

    always_comb begin
        s_ready = 1'b0;
        case (state)
            ST_IDLE:  s_ready = s_valid && o_free;
            ST_RUN:   s_ready = o_free;
            ST_DRAIN: s_ready = 1'b1;
            default:  s_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        finish   = 1'b0;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    if (s_last)
                        state_nx = ST_DONE;
                    else if (new_sym && count == NM_C - CW'(1))
                        state_nx = ST_DRAIN;
                    else
                        state_nx = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (accept && s_last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                // The frame closes only once the last entry has left the output register.
                if (o_free) begin
                    finish   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            prev_llr  <= '0;
            have_prev <= 1'b0;
            order_err <= 1'b0;
            done      <= 1'b0;
            list_len  <= '0;
            m_valid   <= 1'b0;
            m_llr     <= '0;
            m_q       <= '0;
            m_indexa  <= '0;
            m_indexi  <= '0;
        end else begin
            state    <= state_nx;
            done     <= finish;
            list_len <= finish ? count : '0;

            if (new_sym) begin
                m_valid  <= 1'b1;
                m_llr    <= s_llr;
                m_q      <= s_q;
                m_indexa <= s_indexa;
                m_indexi <= s_indexi;
            end else if (m_ready) begin
                m_valid  <= 1'b0;
            end

            if (finish) begin
                count     <= '0;
                prev_llr  <= '0;
                have_prev <= 1'b0;
                order_err <= 1'b0;
            end else if (new_sym) begin
                count     <= count + CW'(1);
                prev_llr  <= s_llr;
                have_prev <= 1'b1;
                if (have_prev && s_llr < prev_llr) order_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sort_list_reader.sv
// Randomized and directed frames against a queue-based reference of the dedup/truncate rule.
module tb_sort_list_reader;
    import sort_list_reader_pkg::*;

    localparam int NM    = 8;
    localparam int LEN_W = len_width(NM);
    localparam int EW    = 6 + 7 + 6 + 6;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             s_last = 1'b0;
    logic [5:0]       s_llr = '0;
    logic [6:0]       s_q = '0;
    logic [5:0]       s_indexa = '0;
    logic [5:0]       s_indexi = '0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [5:0]       m_llr;
    logic [6:0]       m_q;
    logic [5:0]       m_indexa;
    logic [5:0]       m_indexi;
    logic             done;
    logic [LEN_W-1:0] list_len;
    logic             order_err;
    state_t           state_dbg;

    sort_list_reader #(.NM(NM)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .s_llr(s_llr), .s_q(s_q), .s_indexa(s_indexa), .s_indexi(s_indexi),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_llr(m_llr), .m_q(m_q), .m_indexa(m_indexa), .m_indexi(m_indexi),
        .done(done), .list_len(list_len), .order_err(order_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0]    exp_q[$];
    logic [LEN_W-1:0] len_q[$];

    // Current frame description and per-beat expected order_err.
    int fn;
    int fq[64], fl[64], fa[64], fi[64];
    bit oe_after[64];
    int waits[64];
    int rmode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] pack(input int llr, input int q, input int ia, input int ii);
        return {6'(llr), 7'(q), 6'(ia), 6'(ii)};
    endfunction

    // Reference: first occurrence per symbol, at most NM kept, order_err over kept LLRs.
    task automatic model_frame();
        bit seen[int];
        int kept = 0;
        int prev = 0;
        bit oe = 0;
        for (int i = 0; i < fn; i++) begin
            if (kept < NM && !seen.exists(fq[i])) begin
                seen[fq[i]] = 1;
                exp_q.push_back(pack(fl[i], fq[i], fa[i], fi[i]));
                if (kept > 0 && fl[i] < prev) oe = 1;
                prev = fl[i];
                kept++;
            end
            oe_after[i] = oe;
        end
        len_q.push_back(LEN_W'(kept));
    endtask

    task automatic set_beat(input int i, input int q, input int llr);
        fq[i] = q;
        fl[i] = llr;
        fa[i] = $urandom_range(0, 63);
        fi[i] = $urandom_range(0, 63);
    endtask

    task automatic drive_beat(input int i, output int waited);
        bit acc;
        s_valid  = 1'b1;
        s_last   = (i == fn - 1);
        s_llr    = 6'(fl[i]);
        s_q      = 7'(fq[i]);
        s_indexa = 6'(fa[i]);
        s_indexi = 6'(fi[i]);
        waited   = 0;
        acc      = 1'b0;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        if (!acc) check("beat_accept_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (len_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (len_q.size() != 0) begin
            check("done_timeout", 0, 1);
            len_q.delete();
            exp_q.delete();
        end
        check("order_err_cleared", 32'(order_err), 0);
        check("idle_after_done", 32'(state_dbg), 32'(ST_IDLE));
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame();
        model_frame();
        for (int i = 0; i < fn; i++) begin
            drive_beat(i, waits[i]);
            check("order_err_beat", 32'(order_err), 32'(oe_after[i]));
        end
        wait_done();
    endtask

    // Downstream ready: always high, random, or left to the directed test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) m_ready = 1'b1;
            else if (rmode == 1) m_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: compares every delivered entry and every done pulse against the queues.
    logic [EW-1:0] held;
    bit            held_valid = 0;
    initial begin
        logic [EW-1:0] cur;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                held_valid = 0;
            end else begin
                cur = {m_llr, m_q, m_indexa, m_indexi};
                if (m_valid) begin
                    if (held_valid) check("out_hold_stable", 32'(cur), 32'(held));
                    if (m_ready) begin
                        if (exp_q.size() == 0) check("unexpected_out", 32'(cur), 0);
                        else check("out_entry", 32'(cur), 32'(exp_q.pop_front()));
                        held_valid = 0;
                    end else begin
                        held_valid = 1;
                        held = cur;
                    end
                end else begin
                    held_valid = 0;
                end
                if (done) begin
                    if (len_q.size() == 0) check("unexpected_done", 1, 0);
                    else begin
                        check("list_len", 32'(list_len), 32'(len_q.pop_front()));
                        check("done_after_all_out", 32'(exp_q.size()), 0);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int llr;
        int w;
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_list_len", 32'(list_len), 0);
        check("rst_order_err", 32'(order_err), 0);
        check("rst_m_data", 32'({m_llr, m_q, m_indexa, m_indexi}), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: duplicate symbol dropped
        fn = 4;
        set_beat(0, 3, 1); set_beat(1, 5, 2); set_beat(2, 3, 4); set_beat(3, 7, 6);
        run_frame();

        // 2: ten distinct symbols, truncated to NM, tail drained
        fn = 10;
        for (int i = 0; i < 10; i++) set_beat(i, 40 + i, i);
        run_frame();
        check("drain_ready_beat9", 32'(waits[8]), 0);
        check("drain_ready_beat10", 32'(waits[9]), 0);

        // 3: downstream stall with the next beat waiting
        rmode = 2;
        m_ready = 1'b0;
        fn = 3;
        set_beat(0, 10, 1); set_beat(1, 11, 3); set_beat(2, 12, 5);
        model_frame();
        drive_beat(0, w);
        s_valid = 1'b1; s_last = 1'b0;
        s_llr = 6'(fl[1]); s_q = 7'(fq[1]); s_indexa = 6'(fa[1]); s_indexi = 6'(fi[1]);
        repeat (5) begin
            @(negedge clk);
            check("stall_s_ready", 32'(s_ready), 0);
            check("stall_m_valid", 32'(m_valid), 1);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        rmode = 0;
        drive_beat(1, w);
        drive_beat(2, w);
        wait_done();

        // 4: order violation is sticky until the frame closes
        fn = 3;
        set_beat(0, 1, 4); set_beat(1, 2, 2); set_beat(2, 3, 5);
        run_frame();

        // 5: reset mid-frame, then the same symbol again in a fresh frame
        fn = 4;
        set_beat(0, 3, 1); set_beat(1, 4, 2); set_beat(2, 5, 3); set_beat(3, 6, 4);
        for (int i = 0; i < 3; i++) exp_q.push_back(pack(fl[i], fq[i], fa[i], fi[i]));
        for (int i = 0; i < 3; i++) drive_beat(i, w);
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("pre_reset_outputs_drained", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        drive_beat(3, w);
        check("pre_reset_m_valid", 32'(m_valid), 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_m_valid", 32'(m_valid), 0);
        check("async_reset_state", 32'(state_dbg), 32'(ST_IDLE));
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        fn = 1;
        set_beat(0, 3, 2);
        run_frame();

        // 6: s_last on a duplicate in DRAIN while the output is blocked
        rmode = 2;
        m_ready = 1'b1;
        fn = 9;
        for (int i = 0; i < 8; i++) set_beat(i, 20 + i, i);
        set_beat(8, 20, 9);
        model_frame();
        for (int i = 0; i < 8; i++) drive_beat(i, w);
        m_ready = 1'b0;
        drive_beat(8, w);
        check("drain_last_no_wait", 32'(w), 0);
        repeat (4) begin
            @(negedge clk);
            check("done_waits_for_output", 32'(done), 0);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("done_not_in_handshake_cycle", 32'(done), 0);
        @(negedge clk);
        check("done_pulse_after_handshake", 32'(done), 1);
        rmode = 0;
        wait_done();

        // Random frames with random downstream backpressure
        rmode = 1;
        for (int f = 0; f < 25; f++) begin
            fn = $urandom_range(1, 14);
            llr = $urandom_range(0, 10);
            for (int i = 0; i < fn; i++) begin
                if ($urandom_range(0, 5) == 0) llr = llr - $urandom_range(1, 3);
                else llr = llr + $urandom_range(0, 4);
                if (llr < 0) llr = 0;
                if (llr > 63) llr = 63;
                set_beat(i, $urandom_range(0, 11), llr);
            end
            run_frame();
        end
        rmode = 0;

        check("final_exp_q_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
